// File: rtl/ext_pkg.sv
// Shared immediate-extension types and arithmetic for the pipelined and single-cycle cores.
package ext_pkg;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'b00,
      EXT_SIGN  = 2'b01,
      EXT_UPPER = 2'b10,
      EXT_SHL2  = 2'b11
   } ext_mode_t;

   // Widest output any caller may request; callers pass their real widths.
   localparam int unsigned EXT_MAX_W = 64;

   // Legacy single-bit ExtSel: 0 selects zero-extend, 1 selects sign-extend.
   function automatic ext_mode_t ext_from_sel(input logic ext_sel);
      return ext_sel ? EXT_SIGN : EXT_ZERO;
   endfunction

   // Width-generic extender: imm is right-aligned in_w bits, result is right-aligned out_w bits.
   function automatic logic [EXT_MAX_W-1:0] ext_calc(input logic [EXT_MAX_W-1:0] imm,
                                                     input ext_mode_t            mode,
                                                     input int                   in_w,
                                                     input int                   out_w);
      logic [EXT_MAX_W-1:0] field;
      logic [EXT_MAX_W-1:0] sext;
      logic [EXT_MAX_W-1:0] res;
      logic                 sign;
      field = '0;
      sext  = '0;
      res   = '0;
      sign  = 1'b0;
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (i < in_w) field[i] = imm[i];
         if (i == in_w - 1) sign = imm[i];
      end
      for (int i = 0; i < EXT_MAX_W; i++) begin
         sext[i] = (i < in_w) ? field[i] : sign;
      end
      case (mode)
         EXT_ZERO:  res = field;
         EXT_SIGN:  res = sext;
         EXT_UPPER: res = field << (out_w - in_w);
         EXT_SHL2:  res = sext << 2;
         default:   res = field;
      endcase
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (i >= out_w) res[i] = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/ext_skid_buffer.sv
// Generic 2-entry valid/ready skid register: output register plus one skid slot, FIFO order.
module ext_skid_buffer #(
   parameter int unsigned W = 34
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [W-1:0] or_q, or_d;
   logic [W-1:0] sr_q, sr_d;
   logic         ready_q;
   logic         push, pop;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = or_q;
   assign in_ready  = ready_q;
   assign push      = in_valid && ready_q;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      or_d    = or_q;
      sr_d    = sr_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               or_d    = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               or_d = in_data;
            end else if (push) begin
               sr_d    = in_data;
               state_d = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               or_d    = sr_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // ready is registered from the next state so out_ready never reaches in_ready combinationally.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_EMPTY;
         or_q    <= '0;
         sr_q    <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         or_q    <= or_d;
         sr_q    <= sr_d;
         ready_q <= (state_d != ST_FULL);
      end
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender between decode and execute; valid/ready with a 2-entry skid.
module imm_extend_pipe
   import ext_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       ext_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_mode
);

   logic [EXT_MAX_W-1:0] imm_wide;
   logic [EXT_MAX_W-1:0] ext_wide;
   logic [OUT_W+1:0]     skid_in;
   logic [OUT_W+1:0]     skid_out;

   assign imm_wide = EXT_MAX_W'(imm);
   assign ext_wide = ext_calc(imm_wide, ext_mode_t'(ext_mode), int'(IN_W), int'(OUT_W));
   // Mode travels with the result so the consumer can trace which extension produced it.
   assign skid_in  = {ext_mode, ext_wide[OUT_W-1:0]};

   ext_skid_buffer #(
      .W (OUT_W + 2)
   ) u_skid (
      .CLK       (CLK),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (skid_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (skid_out)
   );

   assign out_data = skid_out[OUT_W-1:0];
   assign out_mode = skid_out[OUT_W+:2];

endmodule
